// File: rtl/vproc_pkg.sv
// Shared vector-processor types and sizing constants.
package vproc_pkg;

  localparam int SEW   = 32;
  localparam int VLEN  = 4;
  localparam int NREGS = 32;

  typedef logic [4:0]           vreg_idx_t;
  typedef logic [VLEN*SEW-1:0]  vec_t;

endpackage

// File: rtl/vrf_scoreboard.sv
// Per-register busy scoreboard: marks destinations busy at issue, frees them
// when the register-file write commits, and raises the issue stall on hazards.
module vrf_scoreboard
  import vproc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_issue_valid,
  input  vreg_idx_t        i_issue_rd,
  input  vreg_idx_t        i_issue_rs1,
  input  vreg_idx_t        i_issue_rs2,
  input  logic             i_issue_use_rs1,
  input  logic             i_issue_use_rs2,
  input  logic             i_issue_use_rd,
  input  logic             i_commit,
  input  vreg_idx_t        i_commit_rd,
  output logic             o_issue_stall,
  output logic [NREGS-1:0] o_busy,
  output logic             o_sb_err
);

  logic [NREGS-1:0] r_busy;
  logic             r_sb_err;
  logic [NREGS-1:0] w_busy_next;
  logic             w_issue_fire;
  logic             w_stall;
  logic             w_stray_commit;

  // Hazard detect: any qualified operand that still has a write in flight.
  always_comb begin
    w_stall = i_issue_valid &&
              ((i_issue_use_rs1 && r_busy[i_issue_rs1]) ||
               (i_issue_use_rs2 && r_busy[i_issue_rs2]) ||
               (i_issue_use_rd  && r_busy[i_issue_rd]));
    w_issue_fire   = i_issue_valid && !w_stall;
    w_stray_commit = i_commit && !r_busy[i_commit_rd];
  end

  // Next bitmap: clear the committing register first so a same-cycle set wins.
  always_comb begin
    w_busy_next = r_busy;
    if (i_commit) begin
      w_busy_next[i_commit_rd] = 1'b0;
    end
    if (w_issue_fire && i_issue_use_rd) begin
      w_busy_next[i_issue_rd] = 1'b1;
    end
  end

  // Bitmap and sticky error flag; only reset clears the error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      if (w_stray_commit) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  assign o_issue_stall = w_stall;
  assign o_busy        = r_busy;
  assign o_sb_err      = r_sb_err;

endmodule

// File: rtl/vrf_wb_controller.sv
// Vector register-file write-back controller: round-robin arbiter between the
// ALU and load unit, registered write port, and the busy scoreboard.
module vrf_wb_controller
  import vproc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_alu_valid,
  output logic             o_alu_ready,
  input  vreg_idx_t        i_alu_rd,
  input  vec_t             i_alu_data,
  input  logic             i_lsu_valid,
  output logic             o_lsu_ready,
  input  vreg_idx_t        i_lsu_rd,
  input  vec_t             i_lsu_data,
  output logic             o_reg_write,
  output vreg_idx_t        o_wr_reg,
  output logic [SEW-1:0]   o_write_data0,
  output logic [SEW-1:0]   o_write_data1,
  output logic [SEW-1:0]   o_write_data2,
  output logic [SEW-1:0]   o_write_data3,
  input  logic             i_issue_valid,
  input  vreg_idx_t        i_issue_rd,
  input  vreg_idx_t        i_issue_rs1,
  input  vreg_idx_t        i_issue_rs2,
  input  logic             i_issue_use_rs1,
  input  logic             i_issue_use_rs2,
  input  logic             i_issue_use_rd,
  output logic             o_issue_stall,
  output logic [NREGS-1:0] o_busy,
  output logic             o_sb_err
);

  logic      r_prio;
  logic      r_reg_write;
  vreg_idx_t r_wr_reg;
  vec_t      r_wr_data;
  logic      w_alu_grant;
  logic      w_lsu_grant;

  // Grant selection: a lone requester always wins; on contention prio decides.
  // Nothing is granted while reset is held so no request is consumed.
  always_comb begin
    w_alu_grant = !i_rst && i_alu_valid && (!i_lsu_valid || !r_prio);
    w_lsu_grant = !i_rst && i_lsu_valid && (!i_alu_valid ||  r_prio);
  end

  // Round-robin pointer flips toward whichever side just lost its turn.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio <= 1'b0;
    end else if (w_alu_grant) begin
      r_prio <= 1'b1;
    end else if (w_lsu_grant) begin
      r_prio <= 1'b0;
    end
  end

  // Write-port register: capture the winner, otherwise hold address/data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reg_write <= 1'b0;
      r_wr_reg    <= '0;
      r_wr_data   <= '0;
    end else if (w_alu_grant) begin
      r_reg_write <= 1'b1;
      r_wr_reg    <= i_alu_rd;
      r_wr_data   <= i_alu_data;
    end else if (w_lsu_grant) begin
      r_reg_write <= 1'b1;
      r_wr_reg    <= i_lsu_rd;
      r_wr_data   <= i_lsu_data;
    end else begin
      r_reg_write <= 1'b0;
    end
  end

  vrf_scoreboard u_scoreboard (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_issue_valid   (i_issue_valid),
    .i_issue_rd      (i_issue_rd),
    .i_issue_rs1     (i_issue_rs1),
    .i_issue_rs2     (i_issue_rs2),
    .i_issue_use_rs1 (i_issue_use_rs1),
    .i_issue_use_rs2 (i_issue_use_rs2),
    .i_issue_use_rd  (i_issue_use_rd),
    .i_commit        (r_reg_write),
    .i_commit_rd     (r_wr_reg),
    .o_issue_stall   (o_issue_stall),
    .o_busy          (o_busy),
    .o_sb_err        (o_sb_err)
  );

  assign o_alu_ready   = w_alu_grant;
  assign o_lsu_ready   = w_lsu_grant;
  assign o_reg_write   = r_reg_write;
  assign o_wr_reg      = r_wr_reg;
  assign o_write_data0 = r_wr_data[0*SEW +: SEW];
  assign o_write_data1 = r_wr_data[1*SEW +: SEW];
  assign o_write_data2 = r_wr_data[2*SEW +: SEW];
  assign o_write_data3 = r_wr_data[3*SEW +: SEW];

endmodule

// File: tb/tb_vrf_wb_controller.sv
// Directed self-checking bench for the vector register-file write-back controller.
module tb_vrf_wb_controller;
  import vproc_pkg::*;

  logic             clk;
  logic             rst;
  logic             alu_valid;
  logic             alu_ready;
  vreg_idx_t        alu_rd;
  vec_t             alu_data;
  logic             lsu_valid;
  logic             lsu_ready;
  vreg_idx_t        lsu_rd;
  vec_t             lsu_data;
  logic             reg_write;
  vreg_idx_t        wr_reg;
  logic [SEW-1:0]   wd0, wd1, wd2, wd3;
  logic             issue_valid;
  vreg_idx_t        issue_rd, issue_rs1, issue_rs2;
  logic             use_rs1, use_rs2, use_rd;
  logic             issue_stall;
  logic [NREGS-1:0] busy;
  logic             sb_err;

  int checks;
  int failures;

  vec_t vecA;
  vec_t vecL;

  vrf_wb_controller dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_alu_valid     (alu_valid),
    .o_alu_ready     (alu_ready),
    .i_alu_rd        (alu_rd),
    .i_alu_data      (alu_data),
    .i_lsu_valid     (lsu_valid),
    .o_lsu_ready     (lsu_ready),
    .i_lsu_rd        (lsu_rd),
    .i_lsu_data      (lsu_data),
    .o_reg_write     (reg_write),
    .o_wr_reg        (wr_reg),
    .o_write_data0   (wd0),
    .o_write_data1   (wd1),
    .o_write_data2   (wd2),
    .o_write_data3   (wd3),
    .i_issue_valid   (issue_valid),
    .i_issue_rd      (issue_rd),
    .i_issue_rs1     (issue_rs1),
    .i_issue_rs2     (issue_rs2),
    .i_issue_use_rs1 (use_rs1),
    .i_issue_use_rs2 (use_rs2),
    .i_issue_use_rd  (use_rd),
    .o_issue_stall   (issue_stall),
    .o_busy          (busy),
    .o_sb_err        (sb_err)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives both write requesters in one go.
  task automatic applyStimulus(input logic av, input vreg_idx_t ard, input vec_t ad,
                               input logic lv, input vreg_idx_t lrd, input vec_t ld);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    lsu_valid = lv;
    lsu_rd    = lrd;
    lsu_data  = ld;
  endtask

  task automatic setIssue(input logic v, input vreg_idx_t rd, input vreg_idx_t rs1,
                          input logic urs1, input logic urd);
    issue_valid = v;
    issue_rd    = rd;
    issue_rs1   = rs1;
    issue_rs2   = 5'd0;
    use_rs1     = urs1;
    use_rs2     = 1'b0;
    use_rd      = urd;
  endtask

  // One cycle of reset with all requesters idle.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    setIssue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecA = {32'd4, 32'd3, 32'd2, 32'd1};
    vecL = {32'hD3, 32'hC2, 32'hB1, 32'hA0};

    // Reset held two cycles with both requesters valid.
    rst = 1'b1;
    applyStimulus(1'b1, 5'd1, vecA, 1'b1, 5'd2, vecL);
    setIssue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("rst_alu_ready", 32'(alu_ready), 32'd0);
    checkOutput("rst_lsu_ready", 32'(lsu_ready), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rst_alu_ready2", 32'(alu_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #1;
    checkOutput("rst_reg_write", 32'(reg_write), 32'd0);
    checkOutput("rst_wr_reg", 32'(wr_reg), 32'd0);
    checkOutput("rst_wd0", wd0, 32'd0);
    checkOutput("rst_wd3", wd3, 32'd0);
    checkOutput("rst_busy", busy, 32'd0);
    checkOutput("rst_sb_err", 32'(sb_err), 32'd0);

    // ALU only: rd=5, data {4,3,2,1}.
    @(negedge clk);
    applyStimulus(1'b1, 5'd5, vecA, 1'b0, 5'd0, '0);
    #1;
    checkOutput("alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("alu_lsu_ready", 32'(lsu_ready), 32'd0);
    checkOutput("alu_rw_before", 32'(reg_write), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #1;
    checkOutput("alu_reg_write", 32'(reg_write), 32'd1);
    checkOutput("alu_wr_reg", 32'(wr_reg), 32'd5);
    checkOutput("alu_wd0", wd0, 32'd1);
    checkOutput("alu_wd1", wd1, 32'd2);
    checkOutput("alu_wd2", wd2, 32'd3);
    checkOutput("alu_wd3", wd3, 32'd4);
    @(negedge clk);
    #1;
    checkOutput("alu_rw_after", 32'(reg_write), 32'd0);
    checkOutput("alu_wr_reg_hold", 32'(wr_reg), 32'd5);

    // Contention: grants alternate starting from ALU after reset.
    doReset();
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      applyStimulus(1'b1, 5'd1, vecA, 1'b1, 5'd2, vecL);
      #1;
      checkOutput($sformatf("cont_alu_ready%0d", i), 32'(alu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("cont_lsu_ready%0d", i), 32'(lsu_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i > 0) begin
        checkOutput($sformatf("cont_wr_reg%0d", i), 32'(wr_reg), (i % 2 == 1) ? 32'd1 : 32'd2);
        checkOutput($sformatf("cont_rw%0d", i), 32'(reg_write), 32'd1);
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #1;
    checkOutput("cont_wr_reg4", 32'(wr_reg), 32'd2);
    checkOutput("cont_wd0_lsu", wd0, 32'hA0);
    checkOutput("cont_wd3_lsu", wd3, 32'hD3);

    // RAW stall on register 7.
    doReset();
    setIssue(1'b1, 5'd7, 5'd0, 1'b0, 1'b1);
    #1;
    checkOutput("raw_c1_stall", 32'(issue_stall), 32'd0);
    @(negedge clk);
    setIssue(1'b1, 5'd8, 5'd7, 1'b1, 1'b0);
    #1;
    checkOutput("raw_c2_busy", busy, 32'h0000_0080);
    checkOutput("raw_c2_stall", 32'(issue_stall), 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, 5'd7, vecL, 1'b0, 5'd0, '0);
    #1;
    checkOutput("raw_c3_stall", 32'(issue_stall), 32'd1);
    checkOutput("raw_c3_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #1;
    checkOutput("raw_c4_rw", 32'(reg_write), 32'd1);
    checkOutput("raw_c4_wr_reg", 32'(wr_reg), 32'd7);
    checkOutput("raw_c4_stall", 32'(issue_stall), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("raw_c5_stall", 32'(issue_stall), 32'd0);
    checkOutput("raw_c5_busy", busy, 32'd0);
    checkOutput("raw_c5_sb_err", 32'(sb_err), 32'd0);

    // Set/clear collision on register 9: issue of rd=9 fires while rd=9 commits.
    @(negedge clk);
    setIssue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd9, vecA, 1'b0, 5'd0, '0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    setIssue(1'b1, 5'd9, 5'd0, 1'b0, 1'b1);
    #1;
    checkOutput("col_rw", 32'(reg_write), 32'd1);
    checkOutput("col_wr_reg", 32'(wr_reg), 32'd9);
    checkOutput("col_stall", 32'(issue_stall), 32'd0);
    @(negedge clk);
    setIssue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checkOutput("col_busy9", busy, 32'h0000_0200);
    checkOutput("col_sb_err", 32'(sb_err), 32'd1);

    // Stray LSU write to non-busy register 12.
    doReset();
    #1;
    checkOutput("stray_sb_err_clr", 32'(sb_err), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd12, vecL);
    #1;
    checkOutput("stray_lsu_ready", 32'(lsu_ready), 32'd1);
    checkOutput("stray_alu_ready", 32'(alu_ready), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    #1;
    checkOutput("stray_rw", 32'(reg_write), 32'd1);
    checkOutput("stray_wr_reg", 32'(wr_reg), 32'd12);
    checkOutput("stray_wd1", wd1, 32'hB1);
    @(negedge clk);
    #1;
    checkOutput("stray_sb_err", 32'(sb_err), 32'd1);
    checkOutput("stray_busy", busy, 32'd0);

    // Reset in the cycle after an accept drops the pending write.
    @(negedge clk);
    applyStimulus(1'b1, 5'd3, vecA, 1'b0, 5'd0, '0);
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_rw_pending", 32'(reg_write), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_rw", 32'(reg_write), 32'd0);
    checkOutput("midrst_wr_reg", 32'(wr_reg), 32'd0);
    checkOutput("midrst_sb_err", 32'(sb_err), 32'd0);
    checkOutput("midrst_busy", busy, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
